// File: rtl/vending_pkg.sv
// Shared definitions for the vending datapath: money width, coin codes,
// coin values and the credit-stage state encoding.
package vending_pkg;

  localparam int unsigned MONEY_W = 16;

  // Coin codes as presented by the coin mechanism
  localparam logic [2:0] COIN_1   = 3'd0;
  localparam logic [2:0] COIN_5   = 3'd1;
  localparam logic [2:0] COIN_10  = 3'd2;
  localparam logic [2:0] COIN_25  = 3'd3;
  localparam logic [2:0] COIN_100 = 3'd4;
  localparam logic [2:0] COIN_500 = 3'd5;

  // Coin values in cents
  localparam logic [MONEY_W-1:0] VAL_1   = 16'd1;
  localparam logic [MONEY_W-1:0] VAL_5   = 16'd5;
  localparam logic [MONEY_W-1:0] VAL_10  = 16'd10;
  localparam logic [MONEY_W-1:0] VAL_25  = 16'd25;
  localparam logic [MONEY_W-1:0] VAL_100 = 16'd100;
  localparam logic [MONEY_W-1:0] VAL_500 = 16'd500;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_REFUND = 2'd2
  } state_e;

endpackage

// File: rtl/coin_accumulator_if.sv
// Coin / vend / refund signal bundle for coin_accumulator.
//   slave  : the accumulator (consumes I_*, drives O_*)
//   master : the environment (coin mechanism, vend FSM, hopper)
interface coin_accumulator_if;
  import vending_pkg::*;

  logic               I_COIN_VALID;
  logic [2:0]         I_COIN_TYPE;
  logic               I_SUCCESS;
  logic               I_REFUND;
  logic               I_REFUND_ACK;
  logic [MONEY_W-1:0] O_CHANGE;
  logic [MONEY_W-1:0] O_REFUND;
  logic               O_REFUND_VALID;
  logic               O_REJECT;
  logic [7:0]         O_COIN_COUNT;

  modport slave (
    input  I_COIN_VALID, I_COIN_TYPE, I_SUCCESS, I_REFUND, I_REFUND_ACK,
    output O_CHANGE, O_REFUND, O_REFUND_VALID, O_REJECT, O_COIN_COUNT
  );

  modport master (
    output I_COIN_VALID, I_COIN_TYPE, I_SUCCESS, I_REFUND, I_REFUND_ACK,
    input  O_CHANGE, O_REFUND, O_REFUND_VALID, O_REJECT, O_COIN_COUNT
  );

endinterface

// File: rtl/coin_decode.sv
// Combinational coin code decoder.
//   code_i    : 3-bit coin code
//   value_o   : coin value in cents (0 for invalid codes)
//   invalid_o : code is not a known coin
module coin_decode
  import vending_pkg::*;
(
  input  logic [2:0]         code_i,
  output logic [MONEY_W-1:0] value_o,
  output logic               invalid_o
);

  always_comb begin
    value_o   = '0;
    invalid_o = 1'b0;
    case (code_i)
      COIN_1:   value_o = VAL_1;
      COIN_5:   value_o = VAL_5;
      COIN_10:  value_o = VAL_10;
      COIN_25:  value_o = VAL_25;
      COIN_100: value_o = VAL_100;
      COIN_500: value_o = VAL_500;
      default:  invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/coin_accumulator.sv
// Credit stage ahead of vending_machine: accepts coins, keeps running credit,
// clears it on vend success and runs the refund handshake with the hopper.
//   I_CLK, I_RESET_N : clock, synchronous active-low reset
//   bus (slave)      : coin strobe/type, success, refund request/ack in;
//                      credit, refund amount/valid, reject pulse, coin count out
// All outputs come straight from registers.
module coin_accumulator
  import vending_pkg::*;
#(
  parameter int unsigned MAX_CREDIT = 2000
) (
  input logic                I_CLK,
  input logic                I_RESET_N,
  coin_accumulator_if.slave  bus
);

  state_e             state_q, state_d;
  logic [MONEY_W-1:0] change_q, change_d;
  logic [MONEY_W-1:0] refund_q, refund_d;
  logic               refund_valid_q, refund_valid_d;
  logic               reject_q, reject_d;
  logic [7:0]         count_q, count_d;

  logic [MONEY_W-1:0] coin_val;
  logic               coin_invalid;
  logic [MONEY_W:0]   sum;
  logic               accept;
  logic [7:0]         count_inc;

  coin_decode u_coin_decode (
    .code_i    (bus.I_COIN_TYPE),
    .value_o   (coin_val),
    .invalid_o (coin_invalid)
  );

  // One extra bit so the ceiling compare cannot wrap
  assign sum       = {1'b0, change_q} + {1'b0, coin_val};
  assign accept    = bus.I_COIN_VALID && !coin_invalid && (state_q != S_REFUND) &&
                     (sum <= (MONEY_W + 1)'(MAX_CREDIT));
  assign count_inc = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

  always_comb begin
    state_d        = state_q;
    change_d       = change_q;
    refund_d       = refund_q;
    refund_valid_d = refund_valid_q;
    count_d        = count_q;
    reject_d       = bus.I_COIN_VALID && !accept;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          change_d = sum[MONEY_W-1:0];
          count_d  = count_inc;
          state_d  = S_CREDIT;
        end
      end
      S_CREDIT: begin
        if (bus.I_SUCCESS) begin
          // Success beats refund; a coin arriving with it starts fresh credit
          if (accept) begin
            change_d = coin_val;
            count_d  = 8'd1;
          end else begin
            change_d = '0;
            count_d  = '0;
            state_d  = S_IDLE;
          end
        end else if (bus.I_REFUND) begin
          refund_d       = accept ? sum[MONEY_W-1:0] : change_q;
          refund_valid_d = 1'b1;
          change_d       = '0;
          count_d        = '0;
          state_d        = S_REFUND;
        end else if (accept) begin
          change_d = sum[MONEY_W-1:0];
          count_d  = count_inc;
        end
      end
      S_REFUND: begin
        if (bus.I_REFUND_ACK) begin
          refund_d       = '0;
          refund_valid_d = 1'b0;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RESET_N) begin
      state_q        <= S_IDLE;
      change_q       <= '0;
      refund_q       <= '0;
      refund_valid_q <= 1'b0;
      reject_q       <= 1'b0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      change_q       <= change_d;
      refund_q       <= refund_d;
      refund_valid_q <= refund_valid_d;
      reject_q       <= reject_d;
      count_q        <= count_d;
    end
  end

  assign bus.O_CHANGE       = change_q;
  assign bus.O_REFUND       = refund_q;
  assign bus.O_REFUND_VALID = refund_valid_q;
  assign bus.O_REJECT       = reject_q;
  assign bus.O_COIN_COUNT   = count_q;

endmodule

// File: tb/tb_coin_accumulator.sv
module tb_coin_accumulator;
  import vending_pkg::*;

  logic I_CLK = 1'b0;
  logic I_RESET_N = 1'b0;

  coin_accumulator_if bus ();

  coin_accumulator #(.MAX_CREDIT(2000)) dut (
    .I_CLK     (I_CLK),
    .I_RESET_N (I_RESET_N),
    .bus       (bus)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct {
    logic       rn;
    logic       cv;
    logic [2:0] ct;
    logic       su;
    logic       rf;
    logic       ak;
    int         ch;
    int         cn;
    int         rj;
    int         rv;
    int         ra;
    state_e     st;
  } vec_t;

  typedef struct {
    string  tag;
    int     ch;
    int     cn;
    int     rj;
    int     rv;
    int     ra;
    state_e st;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic vec_t v(int cv, int ct, int su, int rf, int ak,
                             int ch, int cn, int rj, int rv, int ra, state_e st);
    vec_t r;
    r.rn = 1'b1; r.cv = cv[0]; r.ct = ct[2:0]; r.su = su[0]; r.rf = rf[0]; r.ak = ak[0];
    r.ch = ch; r.cn = cn; r.rj = rj; r.rv = rv; r.ra = ra; r.st = st;
    return r;
  endfunction

  task automatic check(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic compare(exp_t e);
    check({e.tag, " change"}, int'(bus.O_CHANGE), e.ch);
    check({e.tag, " count"}, int'(bus.O_COIN_COUNT), e.cn);
    check({e.tag, " reject"}, int'(bus.O_REJECT), e.rj);
    check({e.tag, " refund_valid"}, int'(bus.O_REFUND_VALID), e.rv);
    check({e.tag, " refund"}, int'(bus.O_REFUND), e.ra);
    check({e.tag, " state"}, int'(dut.state_q), int'(e.st));
  endtask

  // Drive one cycle of stimulus, queue its expectation, check after the edge
  task automatic step(vec_t x, string tag);
    exp_t e;
    @(negedge I_CLK);
    I_RESET_N        = x.rn;
    bus.I_COIN_VALID = x.cv;
    bus.I_COIN_TYPE  = x.ct;
    bus.I_SUCCESS    = x.su;
    bus.I_REFUND     = x.rf;
    bus.I_REFUND_ACK = x.ak;
    e.tag = tag; e.ch = x.ch; e.cn = x.cn; e.rj = x.rj; e.rv = x.rv; e.ra = x.ra;
    e.st = x.st;
    exp_q.push_back(e);
    @(posedge I_CLK);
    #1;
    e = exp_q.pop_front();
    compare(e);
  endtask

  initial begin
    vec_t r;

    // cv ct su rf ak | change count rej rv refund state
    tbl.push_back(v(1, 3, 0, 0, 0,   25, 1, 0, 0, 0, S_CREDIT));  // accumulate
    tbl.push_back(v(1, 3, 0, 0, 0,   50, 2, 0, 0, 0, S_CREDIT));
    tbl.push_back(v(1, 4, 0, 0, 0,  150, 3, 0, 0, 0, S_CREDIT));
    tbl.push_back(v(0, 0, 1, 0, 0,    0, 0, 0, 0, 0, S_IDLE));    // vend clear
    tbl.push_back(v(1, 4, 0, 0, 0,  100, 1, 0, 0, 0, S_CREDIT));
    tbl.push_back(v(1, 2, 1, 0, 0,   10, 1, 0, 0, 0, S_CREDIT));  // success + coin
    tbl.push_back(v(0, 0, 1, 0, 0,    0, 0, 0, 0, 0, S_IDLE));
    tbl.push_back(v(1, 5, 0, 0, 0,  500, 1, 0, 0, 0, S_CREDIT));  // build 1800
    tbl.push_back(v(1, 5, 0, 0, 0, 1000, 2, 0, 0, 0, S_CREDIT));
    tbl.push_back(v(1, 5, 0, 0, 0, 1500, 3, 0, 0, 0, S_CREDIT));
    tbl.push_back(v(1, 4, 0, 0, 0, 1600, 4, 0, 0, 0, S_CREDIT));
    tbl.push_back(v(1, 4, 0, 0, 0, 1700, 5, 0, 0, 0, S_CREDIT));
    tbl.push_back(v(1, 4, 0, 0, 0, 1800, 6, 0, 0, 0, S_CREDIT));
    tbl.push_back(v(1, 5, 0, 0, 0, 1800, 6, 1, 0, 0, S_CREDIT));  // over ceiling
    tbl.push_back(v(0, 0, 0, 0, 0, 1800, 6, 0, 0, 0, S_CREDIT));  // pulse ends
    tbl.push_back(v(1, 6, 0, 0, 0, 1800, 6, 1, 0, 0, S_CREDIT));  // invalid code
    tbl.push_back(v(1, 7, 0, 0, 0, 1800, 6, 1, 0, 0, S_CREDIT));
    tbl.push_back(v(0, 0, 1, 0, 0,    0, 0, 0, 0, 0, S_IDLE));
    tbl.push_back(v(1, 5, 0, 0, 0,  500, 1, 0, 0, 0, S_CREDIT));  // build 1500
    tbl.push_back(v(1, 5, 0, 0, 0, 1000, 2, 0, 0, 0, S_CREDIT));
    tbl.push_back(v(1, 5, 0, 0, 0, 1500, 3, 0, 0, 0, S_CREDIT));
    tbl.push_back(v(1, 5, 0, 0, 0, 2000, 4, 0, 0, 0, S_CREDIT));  // limit inclusive
    tbl.push_back(v(1, 0, 0, 0, 0, 2000, 4, 1, 0, 0, S_CREDIT));  // 2001 refused
    tbl.push_back(v(0, 0, 1, 0, 0,    0, 0, 0, 0, 0, S_IDLE));
    tbl.push_back(v(1, 3, 0, 0, 0,   25, 1, 0, 0, 0, S_CREDIT));  // refund of 75
    tbl.push_back(v(1, 3, 0, 0, 0,   50, 2, 0, 0, 0, S_CREDIT));
    tbl.push_back(v(1, 3, 0, 0, 0,   75, 3, 0, 0, 0, S_CREDIT));
    tbl.push_back(v(0, 0, 0, 1, 0,    0, 0, 0, 1, 75, S_REFUND));
    tbl.push_back(v(1, 1, 0, 0, 0,    0, 0, 1, 1, 75, S_REFUND)); // coin refused
    tbl.push_back(v(0, 0, 0, 0, 0,    0, 0, 0, 1, 75, S_REFUND));
    tbl.push_back(v(0, 0, 1, 1, 0,    0, 0, 0, 1, 75, S_REFUND)); // ignored
    tbl.push_back(v(0, 0, 0, 0, 1,    0, 0, 0, 0, 0, S_IDLE));    // ack
    tbl.push_back(v(1, 0, 0, 0, 1,    1, 1, 0, 0, 0, S_CREDIT));  // stray ack
    tbl.push_back(v(0, 0, 1, 0, 0,    0, 0, 0, 0, 0, S_IDLE));
    tbl.push_back(v(1, 4, 0, 0, 0,  100, 1, 0, 0, 0, S_CREDIT));  // priority
    tbl.push_back(v(1, 4, 0, 0, 0,  200, 2, 0, 0, 0, S_CREDIT));
    tbl.push_back(v(0, 0, 1, 1, 0,    0, 0, 0, 0, 0, S_IDLE));    // success wins
    tbl.push_back(v(1, 3, 0, 0, 0,   25, 1, 0, 0, 0, S_CREDIT));
    tbl.push_back(v(1, 3, 0, 0, 0,   50, 2, 0, 0, 0, S_CREDIT));
    tbl.push_back(v(1, 3, 0, 1, 0,    0, 0, 0, 1, 75, S_REFUND)); // refund + coin
    tbl.push_back(v(0, 0, 0, 0, 1,    0, 0, 0, 0, 0, S_IDLE));    // 1-cycle ack
    tbl.push_back(v(0, 0, 0, 1, 0,    0, 0, 0, 0, 0, S_IDLE));    // refund in idle
    tbl.push_back(v(0, 0, 1, 0, 0,    0, 0, 0, 0, 0, S_IDLE));    // success in idle
    tbl.push_back(v(1, 6, 0, 0, 0,    0, 0, 1, 0, 0, S_IDLE));    // invalid in idle

    // Reset state
    I_RESET_N        = 1'b0;
    bus.I_COIN_VALID = 1'b0;
    bus.I_COIN_TYPE  = 3'd0;
    bus.I_SUCCESS    = 1'b0;
    bus.I_REFUND     = 1'b0;
    bus.I_REFUND_ACK = 1'b0;
    r = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_IDLE);
    r.rn = 1'b0;
    step(r, "reset");
    step(r, "reset2");

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    // Reset while a refund is pending drops it; later ack is ignored
    step(v(1, 4, 0, 0, 0, 100, 1, 0, 0, 0, S_CREDIT), "rst_seq coin");
    step(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 100, S_REFUND), "rst_seq refund");
    r = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_IDLE);
    r.rn = 1'b0;
    step(r, "rst_seq reset");
    step(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, S_IDLE), "rst_seq late ack");

    // Coin count saturates at 255 while credit keeps growing
    for (int i = 1; i <= 300; i++) begin
      if (i == 255 || i == 300)
        step(v(1, 0, 0, 0, 0, i, (i > 255) ? 255 : i, 0, 0, 0, S_CREDIT),
             $sformatf("sat%0d", i));
      else begin
        @(negedge I_CLK);
        bus.I_COIN_VALID = 1'b1;
        bus.I_COIN_TYPE  = 3'd0;
        bus.I_SUCCESS    = 1'b0;
        bus.I_REFUND     = 1'b0;
        bus.I_REFUND_ACK = 1'b0;
      end
    end
    step(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, S_IDLE), "sat clear");

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: %0d entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_accumulator.md
# coin_accumulator

Upstream credit stage for `vending_machine`. It accepts coin strobes from the coin mechanism, decodes each coin value and keeps a running credit, which drives `vending_machine.I_CHANGE`. Credit clears when the vend completes (`I_SUCCESS`, wired from `vending_machine.O_SUCCESS`). It also handles the coin-return button through a refund handshake with the hopper.

## Interface

**Parameters**
- `MAX_CREDIT`, default 2000: credit ceiling in cents ($20.00). A coin that would push credit above this value is rejected.

**Ports**
- `I_CLK` in 1: system clock. All logic is on the rising edge.
- `I_RESET_N` in 1: reset, synchronous, active-low.
- `I_COIN_VALID` in 1: one-cycle strobe from the coin mechanism; a coin is present.
- `I_COIN_TYPE` in 3: coin code, valid only while `I_COIN_VALID` is high. Codes: 0=1, 1=5, 2=10, 3=25, 4=100, 5=500. Codes 6 and 7 are invalid.
- `I_SUCCESS` in 1: vend complete; consume the credit.
- `I_REFUND` in 1: coin-return button, sampled as a level.
- `I_REFUND_ACK` in 1: hopper has accepted the refund amount.
- `O_CHANGE` out 16: current credit in cents; feeds `vending_machine.I_CHANGE`.
- `O_REFUND` out 16: amount to return; stable while `O_REFUND_VALID` is high.
- `O_REFUND_VALID` out 1: a refund request is pending.
- `O_REJECT` out 1: one-cycle pulse; the coin was refused and is routed to the return chute.
- `O_COIN_COUNT` out 8: number of coins accepted since the last clear. Saturates at 255.

## Operation

**Reset** (`I_RESET_N` = 0 at a clock edge)
- State goes to `S_IDLE`.
- All outputs go to 0.
- A reset during `S_REFUND` drops the pending refund.

**Coin acceptance**
- A coin is accepted when all of the following hold: `I_COIN_VALID`=1, the code is valid, state ≠ `S_REFUND`, and `O_CHANGE + value <= MAX_CREDIT`.
- The sum is computed in 17 bits, so there is no wrap.
- An accepted coin adds its value to `O_CHANGE` and increments `O_COIN_COUNT`.
- Otherwise `O_REJECT` pulses and credit is unchanged.

**State machine**
- **`S_IDLE`** (credit 0)
  - Accepted coin → `S_CREDIT`.
  - `I_REFUND` and `I_SUCCESS` are ignored.
- **`S_CREDIT`**
  - `I_SUCCESS` → credit and count clear.
  - If a coin is accepted in the same cycle as `I_SUCCESS`, credit becomes that coin's value, count becomes 1, and state stays `S_CREDIT`. Otherwise → `S_IDLE`.
  - `I_REFUND` without `I_SUCCESS` → `S_REFUND`:
    - `O_REFUND` = credit plus any coin accepted in the same cycle.
    - `O_REFUND_VALID` = 1.
    - `O_CHANGE` = 0 and `O_COIN_COUNT` = 0.
  - `I_SUCCESS` and `I_REFUND` in the same cycle: success wins and the refund is ignored.
- **`S_REFUND`**
  - `O_REFUND` and `O_REFUND_VALID` hold.
  - Every coin is rejected. `I_SUCCESS` and `I_REFUND` are ignored.
  - `I_REFUND_ACK` → `S_IDLE`; `O_REFUND_VALID` and `O_REFUND` go to 0.
- `I_REFUND_ACK` outside `S_REFUND` is ignored.
- `O_COIN_COUNT` clears whenever credit clears. It stops at 255, but coins are still accepted.

## Timing

- Every output is registered. There are no combinational paths from input to output.
- Coin strobe at edge N → `O_CHANGE`, `O_COIN_COUNT` or `O_REJECT` updated after edge N.
- `O_REJECT` is high for exactly one cycle per refused coin.
- `I_SUCCESS` at edge N → `O_CHANGE` = 0 (or the new coin's value) after edge N.
- `I_REFUND` at edge N → `O_REFUND_VALID` = 1 after edge N.
- `I_REFUND_ACK` at edge M → `O_REFUND_VALID` = 0 after edge M. The shortest handshake is 1 cycle (ACK already high on the first `S_REFUND` cycle).
- A refund request holds for any number of cycles. The block has no timeout.

## Structure

**Shared package `vending_pkg`:**
- Coin code localparams `COIN_1` … `COIN_500`.
- The `coin_value` lookup constants.
- State encodings `S_IDLE`, `S_CREDIT`, `S_REFUND`.
- The 16-bit money width `MONEY_W`.

Later, `vending_machine` moves to this package as well.

**Sub-module `coin_decode`:** purely combinational. It maps a 3-bit code to a 16-bit value and an invalid flag. The FSM, the adder/compare, and the counters stay in `coin_accumulator`.

## Test plan

1. **Accumulate:** after reset, send coins of type 3, 3, 4 on consecutive cycles → `O_CHANGE` = 25, 50, 150, one cycle after each strobe; `O_COIN_COUNT` = 3; `O_REJECT` never asserts.
2. **Vend clear:**
   - With credit 150, pulse `I_SUCCESS` → `O_CHANGE` = 0 and count = 0 next cycle; state is `S_IDLE`.
   - Repeat with a type-2 coin in the same cycle → `O_CHANGE` = 10, count = 1.
3. **Reject:**
   - With credit 1800, send a type-5 coin → `O_REJECT` is high for 1 cycle and `O_CHANGE` stays 1800.
   - Send type 6 → reject.
   - With credit 1500, send a type-5 coin → accepted, `O_CHANGE` = 2000 (limit inclusive).
4. **Refund handshake:** with credit 75, assert `I_REFUND` → next cycle `O_REFUND_VALID` = 1, `O_REFUND` = 75, `O_CHANGE` = 0.
   - A coin during the pending refund → `O_REJECT`.
   - `I_REFUND_ACK` after 4 cycles → valid and amount go to 0 next cycle; state is `S_IDLE`.
5. **Priority:**
   - With credit 200, assert `I_REFUND` and `I_SUCCESS` together → no refund, `O_CHANGE` = 0.
   - With credit 50, assert `I_REFUND` together with a type-3 coin → `O_REFUND` = 75.
6. **Reset mid-refund:** drive `I_RESET_N` = 0 while `O_REFUND_VALID` = 1 → after the next edge all outputs are 0 and state is `S_IDLE`. A later `I_REFUND_ACK` is ignored.
